id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register carrying decoded operands, the immediate, destination register fields, next-instruction address and the control bundle from decode to execute. Adds a valid/ready handshake for stall, a synchronous flush for bubble insertion, and a saturating stall-cycle counter. An optional skid entry gives a registered upstream ready.

## Interface
- DATA_W, 32, width of operand, immediate and next-instruction fields
- REG_W, 5, width of each destination register index
- ALUOP_W, 3, width of ALU opcode
- CNT_W, 16, width of stall counter
- (derived) CTRL_W = ALUOP_W+7; bundle bit map from LSB: RegDest, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, Branch, then ALUOp[ALUOP_W-1:0]

Ports:
- clk  input  1  rising-edge clock
- res  input  1  asynchronous active-low reset
- iFlush  input  1  discard held and incoming instruction this cycle
- iValid  input  1  decode presents an instruction
- oReady  output  1  register can accept this cycle
- iCtrl  input  CTRL_W  control bundle
- iOperand1, iOperand2, iExtInst, iNextInst  input  DATA_W each  data fields
- iRegDest1, iRegDest2  input  REG_W each  destination candidates
- oValid  output  1  execute stage holds a valid instruction
- iExReady  input  1  execute consumes this cycle
- oCtrl  output  CTRL_W  control bundle; all zero whenever oValid=0
- oOperand1, oOperand2, oExtInst, oNextInst  output  DATA_W each
- oRegDest1, oRegDest2  output  REG_W each
- oStallCnt  output  CNT_W  cycles with oValid=1 and iExReady=0, saturating

## Operation
- Input transfer: iValid & oReady at a rising edge. Output transfer: oValid & iExReady.
- Main register: loads when empty or when its content transfers out in the same cycle; otherwise holds all fields unchanged.
- Bubble: when oValid=0, oCtrl is forced to 0 (RegWrite, MemWrite, MemRead, Branch inactive). Data fields may retain stale values.
- Flush (synchronous): at the edge, oValid<=0, the skid entry is cleared, and the input is dropped even if iValid=1. Flush beats load and stall. oStallCnt is not cleared.
- oStallCnt: increments by 1 on each edge with oValid=1, iExReady=0 and iFlush=0. Holds at 2^CNT_W-1. Cleared only by reset.
- Reset (res=0, any time, including mid-stall): oValid=0, oCtrl=0, all data outputs 0, skid empty, oStallCnt=0. oReady is 1 without skid and 0 while in reset with skid. After release, oReady=1 in both configurations.

## Timing
- Latency: 1 cycle from input transfer to oValid, with no stall.
- Throughput: 1 instruction per cycle while iExReady=1.
- Without skid: oReady = ~oValid | iExReady (combinational from iExReady).
- With skid: oReady = ~skid_full, registered. An input accepted while the main register stalls goes to the skid. The next cycle oReady=0. When the main register transfers out, the skid moves into it and oReady returns to 1 the following edge.
- Ordering is strictly FIFO; no instruction is duplicated or lost except by flush.

## Configuration
- ID_EX_SKID_EN defined: one-entry skid buffer; oReady registered as above; occupancy up to 2.
- ID_EX_SKID_EN undefined: no skid; oReady is combinational; occupancy up to 1.

## Test plan
- Reset: res=0 mid-stream with oValid=1 -> same cycle oValid=0, oCtrl=0, oOperand1=0, oStallCnt=0.
- Pass-through: iValid=1, iExReady=1, iOperand1=0xDEADBEEF, iCtrl RegWrite=1 -> next edge oValid=1, oOperand1=0xDEADBEEF, oCtrl[1]=1; back-to-back stream of 8 emerges in order, one per cycle.
- Stall: hold iExReady=0 for 5 cycles with oValid=1 -> outputs frozen, oStallCnt=5; with skid, a second instruction is held, then oReady=0; releasing iExReady delivers both in order.
- Flush: iFlush=1 with oValid=1 and iValid=1 -> next edge oValid=0, oCtrl=0, skid empty, incoming instruction never appears.
- Saturation: CNT_W=4, stall for 20 cycles -> oStallCnt=15 and holds.
- Simultaneous: main register full, iExReady=1, iValid=1 -> old instruction transfers, new one loads the same edge, oValid stays 1, oStallCnt unchanged.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with valid/ready stall, synchronous flush and a saturating stall counter.
// Optional ID_EX_SKID_EN adds a one-entry skid buffer so that the upstream ready is registered.
`default_nettype none

module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16,
  localparam int CTRL_W = ALUOP_W + 7
) (
  input  logic              clk,
  input  logic              res,
  input  logic              iFlush,
  input  logic              iValid,
  output logic              oReady,
  input  logic [CTRL_W-1:0] iCtrl,
  input  logic [DATA_W-1:0] iOperand1,
  input  logic [DATA_W-1:0] iOperand2,
  input  logic [DATA_W-1:0] iExtInst,
  input  logic [DATA_W-1:0] iNextInst,
  input  logic [REG_W-1:0]  iRegDest1,
  input  logic [REG_W-1:0]  iRegDest2,
  output logic              oValid,
  input  logic              iExReady,
  output logic [CTRL_W-1:0] oCtrl,
  output logic [DATA_W-1:0] oOperand1,
  output logic [DATA_W-1:0] oOperand2,
  output logic [DATA_W-1:0] oExtInst,
  output logic [DATA_W-1:0] oNextInst,
  output logic [REG_W-1:0]  oRegDest1,
  output logic [REG_W-1:0]  oRegDest2,
  output logic [CNT_W-1:0]  oStallCnt
);

  localparam int PAY_W = CTRL_W + 4 * DATA_W + 2 * REG_W;

  logic              main_valid;
  logic [PAY_W-1:0]  main_pay;
  logic [PAY_W-1:0]  in_pay;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic              in_fire;
  logic              out_fire;
  logic              main_free;

  assign in_pay = {iCtrl, iOperand1, iOperand2, iExtInst, iNextInst, iRegDest1, iRegDest2};
  assign {main_ctrl, oOperand1, oOperand2, oExtInst, oNextInst, oRegDest1, oRegDest2} = main_pay;

  // Downstream only ever sees a control bundle while the slot is valid; a bubble is all-zero control.
  assign oValid    = main_valid;
  assign oCtrl     = main_valid ? main_ctrl : '0;
  assign oStallCnt = stall_cnt;

  assign out_fire  = main_valid & iExReady;
  assign main_free = ~main_valid | out_fire;

`ifdef ID_EX_SKID_EN

  logic             skid_valid;
  logic [PAY_W-1:0] skid_pay;
  logic             ready_q;

  assign oReady  = ready_q;
  assign in_fire = iValid & ready_q;

  // ready_q tracks "skid will be empty after this edge"; it resets low so nothing is accepted during reset.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      main_valid <= 1'b0;
      main_pay   <= '0;
      skid_valid <= 1'b0;
      skid_pay   <= '0;
      ready_q    <= 1'b0;
    end else if (iFlush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_pay   <= skid_pay;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) begin
          main_pay <= in_pay;
        end
      end
      ready_q <= 1'b1;
    end else if (in_fire) begin
      skid_pay   <= in_pay;
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= ~skid_valid;
    end
  end

`else

  assign oReady  = main_free;
  assign in_fire = iValid & main_free;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      main_valid <= 1'b0;
      main_pay   <= '0;
    end else if (iFlush) begin
      main_valid <= 1'b0;
    end else if (main_free) begin
      main_valid <= in_fire;
      if (in_fire) begin
        main_pay <= in_pay;
      end
    end
  end

`endif

  // Stall counter is a performance statistic: flush does not clear it, only reset does.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stall_cnt <= '0;
    end else if (main_valid && !iExReady && !iFlush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg; works with or without ID_EX_SKID_EN defined.
`default_nettype none

module tb_id_ex_pipe_reg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;
  localparam int CNT_W   = 4;
  localparam int CTRL_W  = ALUOP_W + 7;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] nxt;
    logic [REG_W-1:0]  rd1;
    logic [REG_W-1:0]  rd2;
  } pay_t;

  logic              clk = 1'b0;
  logic              res = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              ready;
  logic              ex_ready = 1'b0;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_op1, out_op2, out_ext, out_nxt;
  logic [REG_W-1:0]  out_rd1, out_rd2;
  logic [CNT_W-1:0]  stall_cnt;
  pay_t              cur = '0;

  pay_t exp_q[$];
  int   cnt_exp  = 0;
  bit   ready_ok = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .res(res), .iFlush(flush), .iValid(in_valid), .oReady(ready),
    .iCtrl(cur.ctrl), .iOperand1(cur.op1), .iOperand2(cur.op2),
    .iExtInst(cur.ext), .iNextInst(cur.nxt),
    .iRegDest1(cur.rd1), .iRegDest2(cur.rd2),
    .oValid(out_valid), .iExReady(ex_ready), .oCtrl(out_ctrl),
    .oOperand1(out_op1), .oOperand2(out_op2), .oExtInst(out_ext), .oNextInst(out_nxt),
    .oRegDest1(out_rd1), .oRegDest2(out_rd2), .oStallCnt(stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic pay_t rand_pay();
    pay_t p;
    p.ctrl = CTRL_W'($urandom);
    p.op1  = $urandom;
    p.op2  = $urandom;
    p.ext  = $urandom;
    p.nxt  = $urandom;
    p.rd1  = REG_W'($urandom);
    p.rd2  = REG_W'($urandom);
    return p;
  endfunction

  function automatic bit exp_ready_now(input bit xr);
`ifdef ID_EX_SKID_EN
    return ready_ok && (exp_q.size() < 2);
`else
    return (exp_q.size() == 0) || xr;
`endif
  endfunction

  // Called just after a falling edge with `cur` already set; checks, then advances one clock.
  task automatic step(input bit v, input bit xr, input bit fl);
    bit   er, in_fire, out_fire;
    pay_t f;
    in_valid = v;
    ex_ready = xr;
    flush    = fl;
    #1;
    check_eq("valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      check_eq("ctrl", out_ctrl, f.ctrl);
      check_eq("op1", out_op1, f.op1);
      check_eq("op2", out_op2, f.op2);
      check_eq("ext", out_ext, f.ext);
      check_eq("nxt", out_nxt, f.nxt);
      check_eq("rd1", out_rd1, f.rd1);
      check_eq("rd2", out_rd2, f.rd2);
    end else begin
      check_eq("bubble_ctrl", out_ctrl, '0);
    end
    check_eq("stall_cnt", stall_cnt, cnt_exp);
    er = exp_ready_now(xr);
    check_eq("ready", ready, er);
    in_fire  = v && er && !fl;
    out_fire = (exp_q.size() > 0) && xr;
    @(posedge clk);
    if (exp_q.size() > 0 && !xr && !fl && cnt_exp < CNT_MAX) cnt_exp++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) exp_q.push_back(cur);
    end
    ready_ok = 1'b1;
    @(negedge clk);
  endtask

  task automatic step_rand(input bit v, input bit xr, input bit fl);
    cur = rand_pay();
    step(v, xr, fl);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, out_valid, 1'b0);
    check_eq({tag, "_ctrl"}, out_ctrl, '0);
    check_eq({tag, "_op1"}, out_op1, '0);
    check_eq({tag, "_rd1"}, out_rd1, '0);
    check_eq({tag, "_cnt"}, stall_cnt, '0);
`ifdef ID_EX_SKID_EN
    check_eq({tag, "_ready"}, ready, 1'b0);
`else
    check_eq({tag, "_ready"}, ready, 1'b1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_state("rst0");
    res = 1'b1;
    ready_ok = 1'b0;

    // Single pass-through with RegWrite set.
    cur = rand_pay();
    cur.op1  = 32'hDEADBEEF;
    cur.ctrl = 10'b00_0000_0010;
    step(1, 1, 0);
    step_rand(0, 1, 0);
    step_rand(0, 1, 0);
    cur = rand_pay();
    cur.op1  = 32'hDEADBEEF;
    cur.ctrl = 10'b00_0000_0010;
    step(1, 1, 0);
    check_eq("pt_op1", out_op1, 32'hDEADBEEF);
    check_eq("pt_regwrite", out_ctrl[1], 1'b1);

    // Back-to-back stream of 8 at full throughput.
    for (int i = 0; i < 8; i++) step_rand(1, 1, 0);
    check_eq("stream_depth", exp_q.size(), 1);
    step_rand(0, 1, 0);
    step_rand(0, 1, 0);

    // Stall for 5 cycles while upstream keeps offering.
    step_rand(1, 1, 0);
    for (int i = 0; i < 5; i++) step_rand(1, 0, 0);
    check_eq("stall_cnt5", stall_cnt, 5);
    for (int i = 0; i < 3; i++) step_rand(0, 1, 0);

    // Flush with a held instruction and one incoming.
    step_rand(1, 0, 0);
    step_rand(1, 0, 0);
    step_rand(1, 1, 1);
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_ctrl", out_ctrl, '0);
    step_rand(0, 1, 0);

    // Stall long enough to saturate.
    step_rand(1, 1, 0);
    for (int i = 0; i < 20; i++) step_rand(0, 0, 0);
    check_eq("sat_cnt", stall_cnt, CNT_MAX);
    step_rand(0, 0, 0);
    check_eq("sat_hold", stall_cnt, CNT_MAX);

    // Simultaneous transfer in and out keeps the slot full.
    step_rand(1, 1, 0);
    step_rand(1, 1, 0);
    check_eq("simul_valid", out_valid, 1'b1);
    step_rand(0, 1, 0);
    step_rand(0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step_rand($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);

    // Asynchronous reset in the middle of a stall.
    step_rand(1, 1, 0);
    step_rand(1, 0, 0);
    step_rand(1, 0, 0);
    #2;
    res = 1'b0;
    #1;
    check_reset_state("rst_mid");
    exp_q.delete();
    cnt_exp = 0;
    @(negedge clk);
    res = 1'b1;
    ready_ok = 1'b0;
    for (int i = 0; i < 40; i++)
      step_rand($urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
